// File: rtl/reg_file_sb.sv
// Purpose : multi-port register file (r0 hardwired to zero) with per-register busy scoreboard.
// Latency : reads combinational; write->read and reserve/clear->busy take 1 cycle (0 for data with bypass).
// Backpr. : none; every write and reserve is accepted in the cycle it is presented.
//
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding on rd_* ports).
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   rd_addr/rd_data    NUM_RD packed read ports; port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//   rd_busy            busy bit of each addressed register
//   dbg_addr/dbg_data  debug read of committed array contents, never forwarded
//   we0/waddr0/wdata0  write port 0, low priority
//   we1/waddr1/wdata1  write port 1, high priority (wins a same-address collision)
//   rsv_en/rsv_addr    mark a register busy (new in-flight producer)
//   busy_vec           all busy bits, bit 0 always 0
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Requests aimed at r0 are dropped here once, so nothing downstream
    // has to special-case address zero again.
    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;

    assign wr0_ok = we0    && (waddr0   != '0);
    assign wr1_ok = we1    && (waddr1   != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // ------------------------------------------------------------------
    // Storage. mem[0] is only ever loaded by reset, so it stays zero.
    // Port 1 is assigned last so it overrides port 0 on a shared address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. A reserve beats a write-back clear on the same register:
    // the reserving instruction is a newer producer than the one retiring.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < DEPTH; r++) begin
            if (rsv_ok && (rsv_addr == ADDR_W'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if ((wr0_ok && (waddr0 == ADDR_W'(r))) ||
                         (wr1_ok && (waddr1 == ADDR_W'(r)))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Architectural read ports.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        logic [DATA_W-1:0] rd_d;
        logic              rd_b;
`ifdef REGFILE_BYPASS_EN
        logic              hit0;
        logic              hit1;
        logic              hit_rsv;
`endif

        assign rd_a = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        // wrN_ok already excludes r0, so a read of r0 can never be forwarded.
        assign hit0    = wr0_ok && (waddr0   == rd_a);
        assign hit1    = wr1_ok && (waddr1   == rd_a);
        assign hit_rsv = rsv_ok && (rsv_addr == rd_a);
`endif

        always_comb begin
            rd_d = mem[rd_a];
            rd_b = busy[rd_a];
`ifdef REGFILE_BYPASS_EN
            if (hit1) begin
                rd_d = wdata1;
            end else if (hit0) begin
                rd_d = wdata0;
            end
            // The value is being delivered now, so the reader need not stall,
            // unless a new producer is claiming the same register this cycle.
            if ((hit0 || hit1) && !hit_rsv) begin
                rd_b = 1'b0;
            end
`endif
        end

        assign rd_data[k*DATA_W +: DATA_W] = rd_d;
        assign rd_busy[k]                  = rd_b;
    end

    // Debug and scoreboard views always show committed state only.
    assign dbg_data = mem[dbg_addr];
    assign busy_vec = busy;

endmodule
